pipe_hazard_ctrl: RTL and testbench

//  Central hazard/stall/flush controller for the 5-stage RV32I pipeline. Drives the per-register

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl_hzd_wait_timer.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 91 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose: shared constants for the hazard controller (bus width, stage indices, states, bus patterns).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    localparam int NSTG = 5;

    typedef logic [NSTG-1:0] stg_bus_t;

    // Bus bit k corresponds to pipeline register k.
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    // D-mem wait: freeze everything up to EX/MEM, bubble into MEM/WB.
    localparam stg_bus_t DW_STALL = 5'b01111;
    localparam stg_bus_t DW_FLUSH = 5'b10000;
    // Redirect: kill the wrong-path instructions in IF/ID and ID/EX.
    localparam stg_bus_t RD_FLUSH = 5'b00110;
    // Load-use: hold PC and IF/ID, bubble into ID/EX.
    localparam stg_bus_t LU_STALL = 5'b00011;
    localparam stg_bus_t LU_FLUSH = 5'b00100;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose: pipeline-to-hazard-controller bundle (hazard inputs, stall/flush/err outputs).
// Latency: n/a (wires only).
// Backpressure: n/a; stall_o/flush_o are the backpressure towards the pipeline registers.
// Ports: master = pipeline side (drives hazard info, consumes buses); slave = controller.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [4:0] id_r1;
    logic [4:0] id_r2;
    logic       id_use_r1;
    logic       id_use_r2;
    logic [4:0] ex_rd;
    logic       ex_mem_re;
    logic       ex_redirect;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_ack;
    stg_bus_t   stall_o;
    stg_bus_t   flush_o;
    logic       err_o;

    modport master (
        output id_r1, id_r2, id_use_r1, id_use_r2, ex_rd, ex_mem_re, ex_redirect,
               imem_req, imem_ack, dmem_req, dmem_ack,
        input  stall_o, flush_o, err_o
    );

    modport slave (
        input  id_r1, id_r2, id_use_r1, id_use_r2, ex_rd, ex_mem_re, ex_redirect,
               imem_req, imem_ack, dmem_req, dmem_ack,
        output stall_o, flush_o, err_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hzd_wait_timer.sv
// Purpose: counts consecutive memory-wait cycles (saturating) and raises a sticky timeout flag.
// Latency: err_o registered; rises at the edge that closes the WAIT_MAX-th consecutive wait cycle.
// Backpressure: none; observes wait_i only.
// Ports: clk, rst_n (async active-low), wait_i (a wait is in progress this cycle), err_o (sticky).
module hzd_wait_timer #(
    parameter  int WAIT_MAX = 255,
    localparam int CW       = $clog2(WAIT_MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    output logic err_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = '0;
        if (wait_i) begin
            cnt_d = (cnt_q == CW'(WAIT_MAX)) ? cnt_q : cnt_q + CW'(1);
        end
        // Flag on the same edge the counter reaches the limit; only reset clears it.
        err_d = err_q | (cnt_d == CW'(WAIT_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: hazard/stall/flush controller for the 5-stage pipeline (load-use, redirect, I/D-mem waits).
// Latency: stall/flush combinational from state + inputs; state and timeout flag registered.
// Backpressure: stall_o holds registers, flush_o injects bubbles; D-mem wait dominates everything.
// Ports: clk, rst_n (async active-low), hz (slave modport: hazard inputs, stall_o/flush_o/err_o).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.slave    hz
);

    logic [0:0] state_q, state_d;
    stg_bus_t   stall_c, flush_c;
    logic       dmem_wait;
    logic       imem_wait;
    logic       load_use;
    logic       any_wait;

    always_comb begin
        dmem_wait = hz.dmem_req & ~hz.dmem_ack;
        load_use  = hz.ex_mem_re & (hz.ex_rd != 5'd0) &
                    ((hz.id_use_r1 & (hz.ex_rd == hz.id_r1)) |
                     (hz.id_use_r2 & (hz.ex_rd == hz.id_r2)));
        // In DISCARD the stale fetch is by definition in flight until its ack.
        imem_wait = (state_q == ST_DISCARD) ? ~hz.imem_ack : (hz.imem_req & ~hz.imem_ack);
        any_wait  = dmem_wait | imem_wait;

        stall_c = '0;
        flush_c = '0;
        state_d = state_q;

        if (state_q == ST_DISCARD) begin
            // PC already holds the redirect target; drop whatever the old fetch returns.
            stall_c[STG_PC]   = 1'b1;
            flush_c[STG_IFID] = 1'b1;
            if (dmem_wait) begin
                stall_c = stall_c | DW_STALL;
                flush_c = flush_c | DW_FLUSH;
            end
            if (hz.imem_ack) begin
                state_d = ST_RUN;
            end
        end else if (dmem_wait) begin
            // EX is frozen, so a redirect here is re-presented once the access completes.
            stall_c = DW_STALL;
            flush_c = DW_FLUSH;
        end else if (hz.ex_redirect) begin
            flush_c = RD_FLUSH;
            if (hz.imem_req & ~hz.imem_ack) begin
                state_d = ST_DISCARD;
            end
        end else begin
            if (load_use) begin
                stall_c = LU_STALL;
                flush_c = LU_FLUSH;
            end
            if (imem_wait) begin
                stall_c[STG_PC] = 1'b1;
                // A held IF/ID keeps its instruction; only bubble it when it is moving.
                if (!stall_c[STG_IFID]) begin
                    flush_c[STG_IFID] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    hzd_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .wait_i (any_wait),
        .err_o  (hz.err_o)
    );

    // Buses forced quiet while reset is asserted, independent of the clock.
    assign hz.stall_o = rst_n ? stall_c : '0;
    assign hz.flush_o = rst_n ? flush_c : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int WMAX = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: discarding a stale fetch, run length of waits, sticky error.
    bit       m_disc,  m_disc_n;
    int       m_waits, m_waits_n;
    bit       m_err,   m_err_n;
    logic [4:0] exp_stall, exp_flush;

    // Drive one cycle of inputs and predict outputs / next model state from the rules.
    task automatic apply(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic mre, input logic rdr,
                         input logic ireq, input logic iack, input logic dreq, input logic dack);
        bit dw, iw, lu, busy;
        hz.id_r1 = r1; hz.id_r2 = r2; hz.id_use_r1 = u1; hz.id_use_r2 = u2;
        hz.ex_rd = rd; hz.ex_mem_re = mre; hz.ex_redirect = rdr;
        hz.imem_req = ireq; hz.imem_ack = iack; hz.dmem_req = dreq; hz.dmem_ack = dack;
        dw = dreq && !dack;
        iw = ireq && !iack;
        lu = mre && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
        exp_stall = 5'b0; exp_flush = 5'b0; m_disc_n = m_disc; busy = 0;
        if (!rst_n) begin
            m_disc_n = 0;
        end else if (m_disc) begin
            exp_stall = 5'b00001; exp_flush = 5'b00010;
            if (dw) begin exp_stall = exp_stall | 5'b01111; exp_flush = exp_flush | 5'b10000; end
            if (iack) m_disc_n = 0;
            busy = dw || !iack;
        end else if (dw) begin
            exp_stall = 5'b01111; exp_flush = 5'b10000; busy = 1;
        end else if (rdr) begin
            exp_flush = 5'b00110; m_disc_n = iw; busy = iw;
        end else begin
            if (lu) begin exp_stall = 5'b00011; exp_flush = 5'b00100; end
            if (iw) begin exp_stall[0] = 1'b1; if (!lu) exp_flush[1] = 1'b1; end
            busy = iw;
        end
        m_waits_n = busy ? ((m_waits + 1 > WMAX) ? WMAX : m_waits + 1) : 0;
        m_err_n   = m_err || (m_waits_n == WMAX);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_disc = m_disc_n; m_waits = m_waits_n; m_err = m_err_n;
        end else begin
            m_disc = 0; m_waits = 0; m_err = 0;
        end
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        // Inputs that would normally stall everything must be masked in reset.
        apply(1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0);
        #2;
        checks++;
        if (hz.stall_o !== 5'b0 || hz.flush_o !== 5'b0 || hz.err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b flush=%b err=%b want 00000 00000 0",
                     hz.stall_o, hz.flush_o, hz.err_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_disc = 0; m_waits = 0; m_err = 0;
        idle(); #3;
        checks++;
        if (hz.stall_o !== 5'b0 || hz.flush_o !== 5'b0 || hz.err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got stall=%b flush=%b err=%b want 00000 00000 0",
                     hz.stall_o, hz.flush_o, hz.err_o);
        end
        tick();
    endtask

    task automatic test_load_use();
        // 0: hazard on r1; 1: ex_rd=0; 2: id_use_r1=0; 3: hazard on r2; 4: idle after
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: apply(5, 9, 1, 1, 5, 1, 0, 0, 0, 0, 0);
                1: apply(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
                2: apply(5, 9, 0, 1, 5, 1, 0, 0, 0, 0, 0);
                3: apply(7, 12, 1, 1, 12, 1, 0, 0, 0, 0, 0);
                default: idle();
            endcase
            #3;
            checks++;
            if (hz.stall_o !== exp_stall || hz.flush_o !== exp_flush) begin
                errors++;
                $display("FAIL load_use case %0d got stall=%b flush=%b want %b %b",
                         i, hz.stall_o, hz.flush_o, exp_stall, exp_flush);
            end
            tick();
        end
        // Load-use combined with fetch wait: IF/ID held, so no IF/ID bubble.
        apply(5, 0, 1, 0, 5, 1, 0, 1, 0, 0, 0);
        #3;
        checks++;
        if (hz.stall_o !== 5'b00011 || hz.flush_o !== 5'b00100) begin
            errors++;
            $display("FAIL lu_plus_iw got stall=%b flush=%b want 00011 00100", hz.stall_o, hz.flush_o);
        end
        tick();
    endtask

    task automatic test_redirect();
        // Redirect with I-mem idle: one flush cycle, then quiet.
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #3;
            checks++;
            if (hz.stall_o !== exp_stall || hz.flush_o !== exp_flush) begin
                errors++;
                $display("FAIL redirect_idle cyc %0d got stall=%b flush=%b want %b %b",
                         i, hz.stall_o, hz.flush_o, exp_stall, exp_flush);
            end
            tick();
            idle();
        end
        // Redirect with fetch in flight, ack on the 3rd following cycle.
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: apply(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
                1, 2: apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
                3: apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
                default: idle();
            endcase
            #3;
            checks++;
            if (hz.stall_o !== exp_stall || hz.flush_o !== exp_flush) begin
                errors++;
                $display("FAIL redirect_discard cyc %0d got stall=%b flush=%b want %b %b",
                         i, hz.stall_o, hz.flush_o, exp_stall, exp_flush);
            end
            tick();
        end
    endtask

    task automatic test_dmem_wait_redirect();
        // 4 D-mem wait cycles with redirect pending, ack cycle, then redirect re-presented.
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1, 2, 3: apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
                4: apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
                5: apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
                default: idle();
            endcase
            #3;
            checks++;
            if (hz.stall_o !== exp_stall || hz.flush_o !== exp_flush) begin
                errors++;
                $display("FAIL dw_redirect cyc %0d got stall=%b flush=%b want %b %b",
                         i, hz.stall_o, hz.flush_o, exp_stall, exp_flush);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < WMAX + 2; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            #3;
            checks++;
            if (hz.err_o !== (i >= WMAX) || hz.err_o !== m_err || hz.stall_o !== 5'b01111) begin
                errors++;
                $display("FAIL timeout cyc %0d got err=%b stall=%b want err=%b stall=01111",
                         i, hz.err_o, hz.stall_o, (i >= WMAX));
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            #3;
            checks++;
            if (hz.err_o !== 1'b1 || hz.stall_o !== 5'b0) begin
                errors++;
                $display("FAIL err_sticky cyc %0d got err=%b stall=%b want 1 00000", i, hz.err_o, hz.stall_o);
            end
            tick();
        end
        // Reset pulse in the middle of a fresh wait.
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (hz.err_o !== 1'b0 || hz.stall_o !== 5'b0 || hz.flush_o !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got err=%b stall=%b flush=%b want 0 00000 00000",
                     hz.err_o, hz.stall_o, hz.flush_o);
        end
        m_disc = 0; m_waits = 0; m_err = 0;
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
            #3;
            checks++;
            if (hz.stall_o !== exp_stall || hz.flush_o !== exp_flush || hz.err_o !== m_err) begin
                errors++;
                $display("FAIL random cyc %0d got stall=%b flush=%b err=%b want %b %b %b",
                         i, hz.stall_o, hz.flush_o, hz.err_o, exp_stall, exp_flush, m_err);
            end
            tick();
        end
    endtask

    initial begin
        m_disc = 0; m_waits = 0; m_err = 0;
        test_reset();
        test_load_use();
        test_redirect();
        test_dmem_wait_redirect();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
